keypad_scan_zyq: RTL and testbench
==================================

KEYPAD_SCAN_ZYQ -- requirements
Module: keypad_scan_zyq

Interface
REQ-001 SCAN_DIV, default 1000: CLK cycles per column dwell; minimum 2.
REQ-002 DEB_CNT, default 4: consecutive matching samples needed to confirm a press or a release; minimum 1.
REQ-003 REPEAT_SCANS, default 64: samples between auto-repeat pulses; used only under the macro.
REQ-004 CLK  input  1  system clock; every flop samples on its rising edge.
REQ-005 RST_N  input  1  reset; synchronous, active-low.
REQ-006 row  input  4  keypad rows; active-low with external pull-ups; 4'b1111 means no row is active.
REQ-007 col  output  4  column drive; one-hot-low.
REQ-008 key_ack  input  1  consumer acknowledge for key_code.
REQ-009 key_code  output  5  key code; 5'b10000 means no key.
REQ-010 key_valid  output  1  key_code holds a new, unconsumed key.
REQ-011 keypr  output  1  high while a confirmed key is held.

Function
REQ-012 col shall rotate 1110 -> 1101 -> 1011 -> 0111 -> 1110, advancing once every SCAN_DIV cycles in SCAN.
- In all other states col shall stay frozen.
REQ-013 A sample shall occur on the last dwell cycle, when the divider reaches SCAN_DIV-1.
- The divider shall wrap to 0 after that cycle.
REQ-014 {row,col} shall map to key codes as follows.
- Row r1, columns c1..c4: 1, 2, 3, A.
- Row r2, columns c1..c4: 4, 5, 6, B.
- Row r3, columns c1..c4: 7, 8, 9, C.
- Row r4, columns c1..c4: E, 0, F, D.
- Rows and columns are 1-based, c1 = col 1110.
- Codes: 1-9 = 5'b00001-5'b01001, 0 = 5'b00000, A-F = 5'b01010-5'b01111.
- Any row value that is not one-hot-low shall map to 5'b10000.
REQ-015 The FSM shall have states SCAN, DEBOUNCE, HELD and RELEASE.
REQ-016 SCAN: on a sample with a mapped code other than 10000, the FSM shall capture that code, set the match counter to 1 and go to DEBOUNCE.
- If DEB_CNT==1, it shall go straight to HELD.
REQ-017 DEBOUNCE, at each sample:
- Same code: increment the counter; on reaching DEB_CNT, load key_code, set key_valid, go to HELD.
- Any other code, including 10000 or multiple rows: return to SCAN, and col advances normally.
REQ-018 HELD: keypr shall be 1.
- A sample with row==1111 shall start the release count and go to RELEASE.
REQ-019 RELEASE:
- DEB_CNT consecutive samples with row==1111 shall go to SCAN with keypr=0.
- A sample showing the captured code shall return to HELD.
- Any other sample shall continue the release count.
REQ-020 key_valid shall remain 1 until the first cycle with key_valid&key_ack; it shall be 0 the next cycle.
- key_code shall hold its value after the acknowledge.
REQ-021 key_ack while key_valid==0 shall have no effect.
REQ-022 A new confirmed press while key_valid==1 shall overwrite key_code, and key_valid shall stay 1.
- If confirmation and acknowledge occur in the same cycle, key_valid shall be 1 afterward and key_code shall hold the new code.
REQ-023 Press-to-valid latency: key_valid shall assert on the cycle after the DEB_CNT-th matching sample.

Reset
REQ-024 While RST_N==0 at a CLK edge, the block shall set:
- state=SCAN, col=4'b1110;
- key_code=5'b10000, key_valid=0, keypr=0;
- all counters=0.
REQ-025 A reset in the middle of a debounce or hold shall discard the pending key; scanning shall restart at c1 on the first cycle after reset.

Configuration
REQ-026 Macro KEYPAD_AUTOREPEAT_EN, when defined:
- In HELD, key_valid shall re-assert every REPEAT_SCANS samples, keeping the same key_code.
REQ-027 Without KEYPAD_AUTOREPEAT_EN:
- Exactly one key_valid event per press.
- REPEAT_SCANS shall be unused and its counter shall not be built.

Structure
REQ-028 A shared package shall hold:
- the FSM state enum;
- the constant KEY_NONE=5'b10000;
- the column reset pattern 4'b1110;
- the 16 key-code constants.
REQ-029 The combinational {row,col}->code map shall be a sub-module named keypad_map_zyq, reusable by decode logic elsewhere.

Verification (SCAN_DIV=4, DEB_CNT=3, REPEAT_SCANS=8)
REQ-030 Idle: row=1111 -> col cycles 1110,1101,1011,0111, changing every 4 cycles; key_valid=0; key_code=10000.
REQ-031 Press key 5: row=1101 whenever col=1101 -> key_valid=1 with key_code=00101, 1 cycle after the 3rd matching sample; keypr=1.
- Then key_ack=1 for one cycle -> key_valid=0 on the next cycle.
REQ-032 Bounce: row=0111 on c4 for 2 samples, then 1111 -> no key_valid; returns to SCAN; col advances to 1110.
REQ-033 Release: from HELD on key F, row=1111 for 3 samples -> keypr=0 and SCAN resumes.
- A 1-sample glitch back to key F inside the release count -> stay held.
REQ-034 Reset and ghost rows:
- RST_N=0 during DEBOUNCE -> next cycle col=1110, key_code=10000, all flags 0.
- row=1100 (two rows low) -> no press is recognized.
REQ-035 With KEYPAD_AUTOREPEAT_EN, key 0 held and acked each time -> key_valid pulses every 8 samples with key_code=00000.
- Without the macro -> exactly one pulse.

Source files
------------

// File: rtl/keypad_scan_zyq_pkg.sv
// Shared definitions for the keypad scanner: FSM states, key codes, column reset pattern.
// Used by keypad_scan_zyq and keypad_map_zyq (optional KEYPAD_AUTOREPEAT_EN lives in the top).
package keypad_scan_zyq_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } scan_state_e;

  localparam logic [4:0] KEY_NONE  = 5'b10000;
  localparam logic [3:0] COL_RESET = 4'b1110;

  localparam logic [4:0] KEY_0 = 5'd0;
  localparam logic [4:0] KEY_1 = 5'd1;
  localparam logic [4:0] KEY_2 = 5'd2;
  localparam logic [4:0] KEY_3 = 5'd3;
  localparam logic [4:0] KEY_4 = 5'd4;
  localparam logic [4:0] KEY_5 = 5'd5;
  localparam logic [4:0] KEY_6 = 5'd6;
  localparam logic [4:0] KEY_7 = 5'd7;
  localparam logic [4:0] KEY_8 = 5'd8;
  localparam logic [4:0] KEY_9 = 5'd9;
  localparam logic [4:0] KEY_A = 5'd10;
  localparam logic [4:0] KEY_B = 5'd11;
  localparam logic [4:0] KEY_C = 5'd12;
  localparam logic [4:0] KEY_D = 5'd13;
  localparam logic [4:0] KEY_E = 5'd14;
  localparam logic [4:0] KEY_F = 5'd15;

endpackage

// File: rtl/keypad_map_zyq.sv
// Combinational {row,col} -> key code decode for a 4x4 active-low matrix.
// Anything other than exactly one low row and one low column decodes to KEY_NONE.
module keypad_map_zyq
  import keypad_scan_zyq_pkg::*;
(
  input  logic [3:0] row,
  input  logic [3:0] col,
  output logic [4:0] code
);

  logic [1:0] r_idx;
  logic [1:0] c_idx;
  logic       r_ok;
  logic       c_ok;

  always_comb begin
    r_ok  = 1'b1;
    r_idx = 2'd0;
    case (row)
      4'b1110: r_idx = 2'd0;
      4'b1101: r_idx = 2'd1;
      4'b1011: r_idx = 2'd2;
      4'b0111: r_idx = 2'd3;
      default: r_ok  = 1'b0;
    endcase
  end

  always_comb begin
    c_ok  = 1'b1;
    c_idx = 2'd0;
    case (col)
      4'b1110: c_idx = 2'd0;
      4'b1101: c_idx = 2'd1;
      4'b1011: c_idx = 2'd2;
      4'b0111: c_idx = 2'd3;
      default: c_ok  = 1'b0;
    endcase
  end

  always_comb begin
    code = KEY_NONE;
    if (r_ok && c_ok) begin
      case ({r_idx, c_idx})
        4'h0: code = KEY_1;
        4'h1: code = KEY_2;
        4'h2: code = KEY_3;
        4'h3: code = KEY_A;
        4'h4: code = KEY_4;
        4'h5: code = KEY_5;
        4'h6: code = KEY_6;
        4'h7: code = KEY_B;
        4'h8: code = KEY_7;
        4'h9: code = KEY_8;
        4'hA: code = KEY_9;
        4'hB: code = KEY_C;
        4'hC: code = KEY_E;
        4'hD: code = KEY_0;
        4'hE: code = KEY_F;
        4'hF: code = KEY_D;
        default: code = KEY_NONE;
      endcase
    end
  end

endmodule

// File: rtl/keypad_scan_zyq.sv
// 4x4 keypad column scanner with sample-based press/release debounce and a valid/ack key register.
// Define KEYPAD_AUTOREPEAT_EN to re-raise key_valid every REPEAT_SCANS samples while a key is held.
module keypad_scan_zyq
  import keypad_scan_zyq_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEB_CNT      = 4,
  parameter int REPEAT_SCANS = 64
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] row,
  output logic [3:0] col,
  input  logic       key_ack,
  output logic [4:0] key_code,
  output logic       key_valid,
  output logic       keypr,
  output logic [1:0] dbg_state
);

  // Handshake: key_valid stays high until a cycle with key_valid & key_ack;
  // a confirmation in that same cycle wins and keeps key_valid high with the new code.

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEB_CNT + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DEB  = CNT_W'(DEB_CNT);

  localparam logic [1:0] S_SCAN     = ST_SCAN;
  localparam logic [1:0] S_DEBOUNCE = ST_DEBOUNCE;
  localparam logic [1:0] S_HELD     = ST_HELD;
  localparam logic [1:0] S_RELEASE  = ST_RELEASE;

  if (SCAN_DIV < 2 || DEB_CNT < 1 || REPEAT_SCANS < 1) begin : g_bad_params
    $error("keypad_scan_zyq: parameter out of range");
  end

  logic [1:0]       state;
  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] rel_cnt;
  logic [4:0]       cap_code;
  logic [4:0]       map_code;
  logic             sample;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_SCANS + 1);
  localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SCANS - 1);
  logic [REP_W-1:0] rep_cnt;
`endif

  keypad_map_zyq u_map (
    .row  (row),
    .col  (col),
    .code (map_code)
  );

  assign sample    = (div_cnt == DIV_LAST);
  assign dbg_state = state;

  always_ff @(posedge CLK) begin
    if (!RST_N) div_cnt <= '0;
    else        div_cnt <= sample ? '0 : div_cnt + DIV_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= S_SCAN;
      col       <= COL_RESET;
      cap_code  <= KEY_NONE;
      match_cnt <= '0;
      rel_cnt   <= '0;
      key_code  <= KEY_NONE;
      key_valid <= 1'b0;
      keypr     <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt   <= '0;
`endif
    end else begin
      if (key_ack) key_valid <= 1'b0;
      if (sample) begin
        case (state)
          S_SCAN: begin
            if (map_code != KEY_NONE) begin
              cap_code  <= map_code;
              match_cnt <= CNT_ONE;
              if (DEB_CNT == 1) begin
                state     <= S_HELD;
                key_code  <= map_code;
                key_valid <= 1'b1;
                keypr     <= 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                rep_cnt   <= '0;
`endif
              end else begin
                state <= S_DEBOUNCE;
              end
            end else begin
              col <= {col[2:0], col[3]};
            end
          end
          S_DEBOUNCE: begin
            if (map_code == cap_code) begin
              match_cnt <= match_cnt + CNT_ONE;
              if (match_cnt + CNT_ONE == CNT_DEB) begin
                state     <= S_HELD;
                key_code  <= cap_code;
                key_valid <= 1'b1;
                keypr     <= 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                rep_cnt   <= '0;
`endif
              end
            end else begin
              // Bounce: give up on this key and move on to the next column.
              state     <= S_SCAN;
              match_cnt <= '0;
              col       <= {col[2:0], col[3]};
            end
          end
          S_HELD: begin
            if (row == 4'b1111) begin
              if (DEB_CNT == 1) begin
                state     <= S_SCAN;
                keypr     <= 1'b0;
                match_cnt <= '0;
              end else begin
                state   <= S_RELEASE;
                rel_cnt <= CNT_ONE;
              end
            end
`ifdef KEYPAD_AUTOREPEAT_EN
            else if (rep_cnt == REP_LAST) begin
              key_valid <= 1'b1;
              rep_cnt   <= '0;
            end else begin
              rep_cnt <= rep_cnt + REP_ONE;
            end
`endif
          end
          S_RELEASE: begin
            // Only the captured key cancels a release; any other reading counts toward it.
            if (map_code == cap_code) begin
              state   <= S_HELD;
              rel_cnt <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_cnt <= '0;
`endif
            end else if (rel_cnt + CNT_ONE == CNT_DEB) begin
              state     <= S_SCAN;
              keypr     <= 1'b0;
              rel_cnt   <= '0;
              match_cnt <= '0;
            end else begin
              rel_cnt <= rel_cnt + CNT_ONE;
            end
          end
          default: state <= S_SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_zyq.sv
// Bench for keypad_scan_zyq: directed keypad scenarios plus random presses against a sample-level model.
// Build with +define+KEYPAD_AUTOREPEAT_EN to exercise the auto-repeat variant.
module tb_keypad_scan_zyq;

  localparam int SCAN_DIV     = 4;
  localparam int DEB_CNT      = 3;
  localparam int REPEAT_SCANS = 8;

  localparam int M_SCAN = 0;
  localparam int M_DEB  = 1;
  localparam int M_HELD = 2;
  localparam int M_REL  = 3;

  // clock / reset
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] row;
  logic [3:0] col;
  logic       key_ack;
  logic [4:0] key_code;
  logic       key_valid;
  logic       keypr;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  keypad_scan_zyq #(
    .SCAN_DIV     (SCAN_DIV),
    .DEB_CNT      (DEB_CNT),
    .REPEAT_SCANS (REPEAT_SCANS)
  ) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .row       (row),
    .col       (col),
    .key_ack   (key_ack),
    .key_code  (key_code),
    .key_valid (key_valid),
    .keypr     (keypr),
    .dbg_state (dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  // physical keypad: which key the finger is on
  int press_r = -1;
  int press_c = -1;
  bit ghost   = 0;
  bit noise   = 0;

  // behavioural model, one update per clock
  int key_tbl [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
  int m_div = 0, m_idx = 0, m_st = M_SCAN, m_cnt = 0, m_rel = 0, m_rep = 0;
  int m_cap = 16, m_code = 16;
  bit m_valid = 0, m_pr = 0;

  function automatic int key_at(input logic [3:0] r, input int ci);
    if ($countones(~r) != 1) return 16;
    for (int i = 0; i < 4; i++) if (!r[i]) return key_tbl[i*4 + ci];
    return 16;
  endfunction

  function automatic logic [3:0] m_col();
    logic [3:0] c = 4'b1111;
    c[m_idx] = 1'b0;
    return c;
  endfunction

  function automatic logic [3:0] phys_row();
    logic [3:0] r = 4'b1111;
    if (noise) return 4'($urandom_range(0, 15));
    if (press_c == m_idx) begin
      if (ghost) r = 4'b1100;
      else if (press_r >= 0) r[press_r] = 1'b0;
    end
    return r;
  endfunction

  task automatic m_confirm();
    m_code  = m_cap;
    m_valid = 1;
    m_pr    = 1;
    m_st    = M_HELD;
    m_rep   = 0;
  endtask

  task automatic model_step();
    bit smp;
    int code;
    if (!rst_n) begin
      m_div = 0; m_idx = 0; m_st = M_SCAN; m_cnt = 0; m_rel = 0; m_rep = 0;
      m_cap = 16; m_code = 16; m_valid = 0; m_pr = 0;
      return;
    end
    smp  = (m_div == SCAN_DIV - 1);
    code = key_at(row, m_idx);
    if (key_ack) m_valid = 0;
    if (smp) begin
      case (m_st)
        M_SCAN: begin
          if (code != 16) begin
            m_cap = code; m_cnt = 1;
            if (DEB_CNT == 1) m_confirm(); else m_st = M_DEB;
          end else m_idx = (m_idx + 1) % 4;
        end
        M_DEB: begin
          if (code == m_cap) begin
            m_cnt++;
            if (m_cnt == DEB_CNT) m_confirm();
          end else begin
            m_st = M_SCAN; m_idx = (m_idx + 1) % 4;
          end
        end
        M_HELD: begin
          if (row == 4'b1111) begin
            m_rel = 1;
            if (DEB_CNT == 1) begin m_st = M_SCAN; m_pr = 0; end else m_st = M_REL;
          end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
            m_rep++;
            if (m_rep == REPEAT_SCANS) begin m_valid = 1; m_rep = 0; end
`endif
          end
        end
        default: begin
          if (code == m_cap) begin
            m_st = M_HELD; m_rep = 0;
          end else begin
            m_rel++;
            if (m_rel == DEB_CNT) begin m_st = M_SCAN; m_pr = 0; end
          end
        end
      endcase
    end
    m_div = smp ? 0 : m_div + 1;
  endtask

  // scoreboard
  task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %b, expected %b", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("col",       {1'b0, col},     {1'b0, m_col()});
      chk("key_code",  key_code,        5'(m_code));
      chk("key_valid", {4'b0, key_valid}, {4'b0, m_valid});
      chk("keypr",     {4'b0, keypr},   {4'b0, m_pr});
    end
  end

  // driver tasks
  task automatic step();
    #1;
    row = phys_row();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic press(input int r, input int c);
    press_r = r;
    press_c = c;
  endtask

  task automatic wait_model(input int st, input string nm);
    int n = 0;
    while (m_st != st && n < 200) begin
      step();
      n++;
    end
    chk({"wait_", nm}, {4'b0, m_st == st}, 5'd1);
  endtask

  int hold_left = 0;
  int pulses;
  bit prev_v;

  initial begin
    rst_n = 1'b0; key_ack = 1'b0; row = 4'b1111;
    repeat (3) step();
    chk_en = 1;
    chk("rst_col",   {1'b0, col}, 5'b01110);
    chk("rst_code",  key_code, 5'b10000);
    chk("rst_valid", {4'b0, key_valid}, 5'd0);
    chk("rst_keypr", {4'b0, keypr}, 5'd0);

    // key 5: sampled on c2 at edges 8, 12, 16 after reset release
    rst_n = 1'b1;
    press(1, 1);
    repeat (4) step();
    chk("idle_col_c2", {1'b0, col}, 5'b01101);
    repeat (11) step();
    chk("k5_pre", {4'b0, key_valid}, 5'd0);
    step();
    chk("k5_valid", {4'b0, key_valid}, 5'd1);
    chk("k5_code",  key_code, 5'b00101);
    chk("k5_keypr", {4'b0, keypr}, 5'd1);
    key_ack = 1'b1; step(); key_ack = 1'b0;
    chk("k5_ack",  {4'b0, key_valid}, 5'd0);
    chk("k5_code_kept", key_code, 5'b00101);
    press(-1, -1);
    repeat (10) step();
    chk("k5_still_held", {4'b0, keypr}, 5'd1);
    step();
    chk("k5_released", {4'b0, keypr}, 5'd0);

    // bounce on key D (row 4, col 4) for two samples
    press(3, 3);
    wait_model(M_DEB, "d_deb");
    for (int n = 0; n < 40 && m_cnt < 2; n++) step();
    press(-1, -1);
    wait_model(M_SCAN, "d_scan");
    chk("bounce_col",   {1'b0, col}, 5'b01110);
    chk("bounce_valid", {4'b0, key_valid}, 5'd0);

    // key F with a one-sample glitch inside the release count
    press(3, 2);
    wait_model(M_HELD, "f_held");
    chk("f_code", key_code, 5'b01111);
    key_ack = 1'b1; step(); key_ack = 1'b0;
    press(-1, -1);
    wait_model(M_REL, "f_rel");
    press(3, 2);
    wait_model(M_HELD, "f_reheld");
    chk("f_glitch_keypr", {4'b0, keypr}, 5'd1);
    press(-1, -1);
    wait_model(M_SCAN, "f_scan");
    chk("f_release_keypr", {4'b0, keypr}, 5'd0);

    // reset while debouncing
    press(1, 1);
    wait_model(M_DEB, "r_deb");
    rst_n = 1'b0; step(); rst_n = 1'b1;
    press(-1, -1);
    chk("mid_rst_col",   {1'b0, col}, 5'b01110);
    chk("mid_rst_code",  key_code, 5'b10000);
    chk("mid_rst_valid", {4'b0, key_valid}, 5'd0);
    chk("mid_rst_keypr", {4'b0, keypr}, 5'd0);

    // two rows low on one column
    ghost = 1; press_c = 2;
    repeat (64) step();
    chk("ghost_valid", {4'b0, key_valid}, 5'd0);
    chk("ghost_keypr", {4'b0, keypr}, 5'd0);
    ghost = 0; press(-1, -1);

    // key 0 held and acked each time
    press(3, 1);
    wait_model(M_HELD, "z_held");
    pulses = key_valid ? 1 : 0;
    prev_v = key_valid;
    for (int n = 0; n < 96; n++) begin
      key_ack = m_valid;
      step();
      if (key_valid && !prev_v) pulses++;
      prev_v = key_valid;
    end
    key_ack = 1'b0;
    chk("z_code", key_code, 5'b00000);
`ifdef KEYPAD_AUTOREPEAT_EN
    chk("z_pulses", 5'(pulses), 5'd4);
`else
    chk("z_pulses", 5'(pulses), 5'd1);
`endif
    press(-1, -1);
    repeat (20) step();

    // random presses, bounces, noise, acks and rare resets
    for (int i = 0; i < 2500; i++) begin
      if (hold_left == 0) begin
        if ($urandom_range(0, 2) == 0) press(-1, -1);
        else press($urandom_range(0, 3), $urandom_range(0, 3));
        ghost = ($urandom_range(0, 15) == 0);
        if (ghost) press_c = $urandom_range(0, 3);
        hold_left = $urandom_range(1, 80);
      end
      hold_left--;
      noise   = ($urandom_range(0, 30) == 0);
      key_ack = ($urandom_range(0, 3) == 0);
      rst_n   = ($urandom_range(0, 999) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
